frame_buffer_arbiter: RTL
=========================

# frame_buffer_arbiter

Shares the single port of the frame-buffer block RAM between the camera capture path (writes) and the VGA display path (reads). The display side is driven by the sync pulse generator's `video_en_o`/`pixel_o`. Each 320x240 buffer address is presented for 4 pixel clocks, so the arbiter spends one cycle per address on a read and gives the idle slots to queued camera writes. Camera writes are absorbed by an internal FIFO with a valid/ready handshake.

## Interface
- `ADDR_WIDTH`, default 17: frame-buffer address width (76800 locations).
- `DATA_WIDTH`, default 12: pixel width (RGB444).
- `FIFO_DEPTH`, default 8: camera write FIFO entries; must be a power of two, ≥2.
- `clk_i`  in  1  pixel clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `video_en_i`  in  1  display active region, from the sync pulse generator.
- `pixel_i`  in  ADDR_WIDTH  display buffer address, from the sync pulse generator.
- `cam_valid_i`  in  1  camera write request.
- `cam_addr_i`  in  ADDR_WIDTH  camera write address.
- `cam_data_i`  in  DATA_WIDTH  camera write data.
- `cam_ready_o`  out  1  FIFO can accept; a write transfers when `cam_valid_i && cam_ready_o`.
- `mem_en_o`  out  1  RAM port enable.
- `mem_we_o`  out  1  RAM write enable.
- `mem_addr_o`  out  ADDR_WIDTH  RAM address.
- `mem_wdata_o`  out  DATA_WIDTH  RAM write data.
- `mem_rdata_i`  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read.
- `pixel_data_o`  out  DATA_WIDTH  registered display pixel.
- `pixel_valid_o`  out  1  one-cycle pulse when `pixel_data_o` updates.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- State: `rd_addr_q` and `rd_addr_valid_q`, the last address read. Reset sets `rd_addr_valid_q` to 0.
- Read request: `rd_req = video_en_i && (!rd_addr_valid_q || pixel_i != rd_addr_q)`.
- Port decision is combinational, per cycle, fixed priority:
  - `rd_req` → read: `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o`=`pixel_i`. Also load `rd_addr_q`←`pixel_i`, `rd_addr_valid_q`←1.
  - else FIFO not empty → write the FIFO head: `mem_en_o`=1, `mem_we_o`=1, addr/data = head. The head is popped this cycle.
  - else idle: `mem_en_o`=0, `mem_we_o`=0. Addr/data stay 0.
- Reads always win; a read is never delayed.
- Read data capture:
  - `rd_pending_q` is set on the cycle a read is issued.
  - On the next cycle, `pixel_data_o`←`mem_rdata_i` at that clock edge and `pixel_valid_o`=1 for one cycle.
  - Otherwise `pixel_data_o` holds its value.
- FIFO: circular buffer with write/read pointers and a count.
  - `cam_ready_o = !reset_i && (count != FIFO_DEPTH)`. It does not depend on a same-cycle pop.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop when empty never occurs.
  - No bypass: an entry accepted at edge t is written to RAM no earlier than the cycle after t.
- Write order to RAM equals acceptance order.
- `video_en_i` low → no reads; the FIFO drains one entry per cycle.
- Address wrap/frame restart needs no special case: `pixel_i` returning to 0 differs from `rd_addr_q`, so a read is issued.

## Timing
- Reset values: `pixel_data_o`=0, `pixel_valid_o`=0, `fifo_count_o`=0, `cam_ready_o`=0 while `reset_i` is high, `mem_en_o`=`mem_we_o`=0, `mem_addr_o`=`mem_wdata_o`=0.
  - FIFO contents are discarded and `rd_pending_q` is cleared.
  - A read in flight at reset produces no `pixel_valid_o`.
- Display latency:
  - `pixel_i` changes in cycle t → read issued in cycle t.
  - `pixel_data_o` updates and `pixel_valid_o` pulses in cycle t+2 (visible after the edge ending cycle t+1).
- With the sync generator's 4-cycle-per-address cadence, at least 3 write slots are free per 4 active cycles.
  - Sustained camera rate ≤ 3/4 word/cycle in active video and 1 word/cycle in blanking never backpressures.
- FIFO full: `cam_ready_o`=0 and the camera holds. `cam_ready_o` reasserts the cycle after the first pop.

## Test plan
- Reset mid-operation: assert `reset_i` with 5 FIFO entries and a read in flight → all outputs take reset values next cycle, no `pixel_valid_o`, and `fifo_count_o`=0.
- Blanking drain: `video_en_i`=0; push (addr 10, data 0xABC) then (addr 11, data 0x123) → RAM writes in the following consecutive cycles, in that order; `fifo_count_o` returns to 0.
- Read priority: `video_en_i`=1, `pixel_i` steps 0→1 every 4 cycles with the FIFO non-empty → reads only on change cycles and writes on the other 3.
  - With RAM preloaded (addr 1 = 0x5A5), `pixel_data_o`=0x5A5 and `pixel_valid_o` pulses exactly 2 cycles after `pixel_i` becomes 1.
- Full/backpressure: hold `video_en_i`=1 with `pixel_i` changing every cycle and push 9 words at `FIFO_DEPTH`=8 → `cam_ready_o` drops after 8 and no words are lost.
  - Release (`video_en_i`=0) → all 9 written in order.
- Simultaneous push/pop at count 3 → count stays 3; ordering preserved.
- Frame wrap: `pixel_i` 76799 → 0 → read of address 0 issued in the wrap cycle.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer port arbiter: display reads take the single RAM port whenever the
// display address changes; all other cycles drain a small camera write FIFO.
module frame_buffer_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          video_en_i,
  input  logic [ADDR_WIDTH-1:0]         pixel_i,
  input  logic                          cam_valid_i,
  input  logic [ADDR_WIDTH-1:0]         cam_addr_i,
  input  logic [DATA_WIDTH-1:0]         cam_data_i,
  output logic                          cam_ready_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  output logic [DATA_WIDTH-1:0]         pixel_data_o,
  output logic                          pixel_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_addr_valid_q, rd_addr_valid_d;
  logic                  rd_pending_q;
  logic [DATA_WIDTH-1:0] pixel_data_q;
  logic                  pixel_valid_q;

  logic [EntryW-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic                  rd_req;
  logic                  push;
  logic                  pop;
  logic [EntryW-1:0]     head;

  assign head         = fifo_mem_q[rd_ptr_q];
  assign cam_ready_o  = !reset_i && (count_q != CntW'(FIFO_DEPTH));
  assign push         = cam_valid_i && cam_ready_o;
  assign fifo_count_o = count_q;
  assign pixel_data_o = pixel_data_q;
  assign pixel_valid_o = pixel_valid_q;

  // Port decision: a changed display address always wins, otherwise drain the FIFO head.
  always_comb begin
    rd_req          = 1'b0;
    pop             = 1'b0;
    mem_en_o        = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    rd_addr_d       = rd_addr_q;
    rd_addr_valid_d = rd_addr_valid_q;
    if (!reset_i) begin
      rd_req = video_en_i && (!rd_addr_valid_q || (pixel_i != rd_addr_q));
      if (rd_req) begin
        mem_en_o        = 1'b1;
        mem_addr_o      = pixel_i;
        rd_addr_d       = pixel_i;
        rd_addr_valid_d = 1'b1;
      end else if (count_q != '0) begin
        pop         = 1'b1;
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = head[EntryW-1:DATA_WIDTH];
        mem_wdata_o = head[DATA_WIDTH-1:0];
      end
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: last read address, FIFO pointers, read-data capture pipeline.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_addr_q       <= '0;
      rd_addr_valid_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      rd_pending_q    <= 1'b0;
      pixel_data_q    <= '0;
      pixel_valid_q   <= 1'b0;
    end else begin
      rd_addr_q       <= rd_addr_d;
      rd_addr_valid_q <= rd_addr_valid_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      rd_pending_q    <= rd_req;
      pixel_valid_q   <= rd_pending_q;
      if (rd_pending_q) pixel_data_q <= mem_rdata_i;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {cam_addr_i, cam_data_i};
  end

endmodule
